// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port and the data (load/store) port. One transaction is in flight at a time.
// The data port has priority, but a streak limiter hands the memory to a waiting
// fetch after MAX_D_STREAK consecutive data grants.
// Optional build macro: ARB_TIMEOUT_EN -- aborts a transaction that sees no
// mem_ack within TIMEOUT_CYCLES busy cycles (done pulse with err = 1).
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  // instruction-fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_size,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int            SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_streak;

  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [1:0]    r_mem_size;

  logic          w_idle;
  logic          w_grant_d;
  logic          w_grant_i;
  logic          w_grant;
  logic          w_timeout;
  logic          w_complete;
  logic          w_abort;
  logic [DW-1:0] w_rdata;

  // Grant decision is only made while idle; data wins unless a waiting fetch
  // has already been passed over MAX_D_STREAK times in a row.
  assign w_idle    = (r_state == IDLE);
  assign w_grant_d = w_idle && d_req && (!if_req || (r_streak < STREAK_MAX));
  assign w_grant_i = w_idle && !w_grant_d && if_req;
  assign w_grant   = w_grant_d || w_grant_i;

`ifdef ARB_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;

  // Busy-cycle counter: cleared on each grant, counts while a transaction waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_grant) begin
      r_to_cnt <= '0;
    end else if (!w_idle && (r_to_cnt != TO_LAST)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // The TIMEOUT_CYCLES-th busy cycle without an ack is the abort cycle.
  assign w_timeout = !w_idle && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // A transaction ends on an ack, or on the abort cycle; an ack wins over abort.
  assign w_complete = !w_idle && (mem_ack || w_timeout);
  assign w_abort    = w_complete && !mem_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_complete) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: done pulses, err and read data are combinational in the ack cycle.
  always_comb begin
    if_done = 1'b0;
    d_done  = 1'b0;
    err     = 1'b0;
    w_rdata = '0;
    if (w_complete) begin
      if (r_state == BUSY_I) begin
        if_done = 1'b1;
      end
      if (r_state == BUSY_D) begin
        d_done = 1'b1;
      end
      err = w_abort;
      // stores and aborted transactions return zero
      if (!w_abort && !r_mem_we) begin
        w_rdata = mem_rdata;
      end
    end
  end

  // Command register: captured at grant, held stable until the transaction ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= 2'b00;
    end else if (w_grant) begin
      r_mem_req <= 1'b1;
      if (w_grant_d) begin
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_mem_size  <= d_size;
      end else begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= if_addr;
        r_mem_size <= 2'b10;
      end
    end else if (w_complete) begin
      r_mem_req <= 1'b0;
    end
  end

  // Streak of data grants that overtook a waiting fetch; any other grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_grant_d) begin
      if (!if_req) begin
        r_streak <= '0;
      end else if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + 1'b1;
      end
    end else if (w_grant_i) begin
      r_streak <= '0;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_size  = r_mem_size;

  assign if_rdata = w_rdata;
  assign d_rdata  = w_rdata;
  assign if_stall = if_req && !if_done;
  assign d_stall  = d_req && !d_done;
  assign busy     = !w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized fetch/data requesters, a memory
// responder with random latency, and a scoreboard monitor that checks grant
// order, grant timing, command payload, completion data and err flags.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q_if[$];
  exp_t q_d[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%s expected=%s", name, got, exp);
    end
  endtask

  // Memory contents: a reference image (updated when a request is issued) and
  // the memory device itself (updated when the memory acknowledges).
  logic [31:0] mdl [logic [31:0]];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : init_val(a);
  endfunction

  function logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  // ---------------- memory responder ----------------
  int   fixed_lat = -1;
  bit   resp_en   = 1'b1;
  logic force_ack = 1'b0;
  bit   r_in      = 1'b0;
  int   r_cnt     = 0;
  int   r_lat     = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!resp_en) begin
        r_in    = 1'b0;
        mem_ack = force_ack;
      end else if (mem_req) begin
        if (!r_in) begin
          r_in  = 1'b1;
          r_cnt = 0;
          r_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        end
        if (r_cnt == r_lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem_rd(mem_addr);
          r_in = 1'b0;
        end else begin
          r_cnt++;
        end
      end else begin
        r_in = 1'b0;
        // stray acks while idle must be ignored
        if ($urandom_range(0, 5) == 0) mem_ack = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic        m_prev_i = 0, m_prev_d = 0, m_prev_req = 0, m_busy_prev = 0;
  logic        m_in_txn = 0, m_txn_d = 0, m_done_prev = 0;
  logic        m_rise, m_exp_rise, m_exp_d;
  int          m_streak = 0;
  logic [31:0] m_cap_addr, m_cap_wdata;
  logic        m_cap_we;
  logic [1:0]  m_cap_size;
  string       order = "";
  exp_t        m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev_i = 0; m_prev_d = 0; m_prev_req = 0; m_busy_prev = 0;
      m_in_txn = 0; m_done_prev = 0; m_streak = 0;
    end else begin
      m_rise     = mem_req && !m_prev_req;
      m_exp_rise = !m_busy_prev && (m_prev_i || m_prev_d);
      if (m_rise || m_exp_rise) check("grant_timing", m_rise, m_exp_rise);
      if (m_rise) begin
        m_exp_d = m_prev_d && (!m_prev_i || m_streak < MAXS);
        if (m_exp_d) begin
          check("cmd_d", {mem_we, mem_size, mem_addr}, {d_we, d_size, d_addr});
          check("cmd_d_wdata", mem_wdata, d_wdata);
          m_streak = m_prev_i ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
          order = {order, "D"};
        end else begin
          check("cmd_i", {mem_we, mem_size, mem_addr}, {1'b0, 2'b10, if_addr});
          m_streak = 0;
          order = {order, "I"};
        end
        m_cap_addr = mem_addr; m_cap_we = mem_we; m_cap_size = mem_size; m_cap_wdata = mem_wdata;
        m_in_txn = 1'b1;
        m_txn_d  = m_exp_d;
      end else if (m_in_txn) begin
        check("cmd_stable", {mem_req, mem_we, mem_size, mem_addr}, {1'b1, m_cap_we, m_cap_size, m_cap_addr});
        if (m_txn_d) check("wdata_stable", mem_wdata, m_cap_wdata);
      end
      m_busy_prev = m_in_txn;
      if (if_done || d_done) begin
        if (!m_in_txn) check("done_unexpected", {if_done, d_done}, 2'b00);
        else           check("done_port", {if_done, d_done}, m_txn_d ? 2'b01 : 2'b10);
        if (if_done) begin
          if (q_if.size() == 0) check("if_done_no_exp", 1, 0);
          else begin
            m_e = q_if.pop_front();
            check("if_rdata", if_rdata, m_e.rdata);
            check("if_err", err, m_e.err);
          end
        end
        if (d_done) begin
          if (q_d.size() == 0) check("d_done_no_exp", 1, 0);
          else begin
            m_e = q_d.pop_front();
            check("d_rdata", d_rdata, m_e.rdata);
            check("d_err", err, m_e.err);
          end
        end
        m_in_txn = 1'b0;
      end
      if (m_done_prev) check("idle_after_done", {busy, mem_req}, 2'b00);
      m_done_prev = if_done || d_done;
      m_prev_i    = if_req;
      m_prev_d    = d_req;
      m_prev_req  = mem_req;
    end
  end

  // ---------------- requesters ----------------
  bit abort_next = 1'b0;

  // Called just after a rising edge; returns after dropping the request at the done edge.
  task automatic fetch_req(input logic [31:0] a, output int lat);
    exp_t e;
    bit   got = 1'b0;
    if_req  = 1'b1;
    if_addr = a;
    e.rdata = mdl_rd(a);
    e.err   = 1'b0;
    q_if.push_back(e);
    lat = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (if_done) got = 1'b1;
    end
    if (!got) check("fetch_wait", 0, 1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, output int lat);
    exp_t e;
    bit   got = 1'b0;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_size  = sz;
    if (abort_next) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else if (we) begin
      mdl[a]  = wd;
      e.rdata = '0;
      e.err   = 1'b0;
    end else begin
      e.rdata = mdl_rd(a);
      e.err   = 1'b0;
    end
    q_d.push_back(e);
    lat = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (d_done) got = 1'b1;
    end
    if (!got) check("data_wait", 0, 1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic gap_wait(input int gapmax);
    int g;
    g = (gapmax == 0 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, gapmax));
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic data_drv(input int n, input int gapmax, input bit loads_only);
    int l;
    for (int i = 0; i < n; i++) begin
      gap_wait(gapmax);
      data_req(loads_only ? 1'b0 : 1'($urandom_range(0, 1)),
               32'h2000 + 32'(4 * $urandom_range(0, 15)), $urandom,
               2'($urandom_range(0, 3)), l);
    end
  endtask

  task automatic fetch_drv(input int n, input int gapmax);
    int l;
    for (int i = 0; i < n; i++) begin
      gap_wait(gapmax);
      fetch_req(32'h1000 + 32'(4 * $urandom_range(0, 255)), l);
    end
  endtask

  // ---------------- main sequence ----------------
  int  lat_a, lat_b;
  bit  seen;

  initial begin
    rst_n   = 1'b0;
    if_req  = 1'b0; if_addr = '0;
    d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = 2'b00;
    mem[32'h100] = 32'hDEADBEEF;
    mdl[32'h100] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {mem_req, mem_we, busy, if_done, d_done, err}, 6'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_size", mem_size, 0);
    check("rst_stall", {if_stall, d_stall}, 2'b00);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // fetch only, memory answers two cycles after mem_req
    fixed_lat = 2;
    fetch_req(32'h100, lat_a);
    check("fetch_latency", lat_a, 4);

    // same-cycle ack, then a back-to-back data request at the done edge
    fixed_lat = 0;
    data_req(1'b0, 32'h2008, 32'h0, 2'b10, lat_a);
    check("same_cycle_latency", lat_a, 2);
    data_req(1'b0, 32'h200C, 32'h0, 2'b10, lat_a);
    check("back_to_back_latency", lat_a, 2);
    fixed_lat = -1;

    // simultaneous store and fetch: data first
    order = "";
    fork
      data_req(1'b1, 32'h200, 32'h11223344, 2'b01, lat_a);
      fetch_req(32'h1040, lat_b);
    join
    check_str("simul_order", order, "DI");
    data_req(1'b0, 32'h200, 32'h0, 2'b10, lat_a);

    // data port hogging with a fetch waiting
    order = "";
    fork
      data_drv(6, 0, 1'b1);
      fetch_req(32'h1080, lat_b);
    join
    check_str("starve_order", order, "DDDDIDD");

    // randomized traffic
    fork
      data_drv(40, 2, 1'b0);
      fetch_drv(40, 3);
    join

    // reset while a data transaction is in flight
    resp_en   = 1'b0;
    force_ack = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2010; d_size = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check("rst_test_grant", seen, 1);
    check("stall_while_busy", {d_stall, if_stall}, 2'b10);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {mem_req, busy, d_done}, 3'b000);
    @(posedge clk); #1;
    d_req     = 1'b0;
    force_ack = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ack_in_idle", {if_done, d_done, busy, mem_req, err}, 5'b0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    resp_en   = 1'b1;
    fetch_req(32'h10A0, lat_a);

`ifdef ARB_TIMEOUT_EN
    // memory never answers: abort after TO busy cycles, then normal traffic
    resp_en    = 1'b0;
    force_ack  = 1'b0;
    abort_next = 1'b1;
    data_req(1'b0, 32'h2014, 32'h0, 2'b10, lat_a);
    abort_next = 1'b0;
    check("timeout_latency", lat_a, TO + 1);
    resp_en = 1'b1;
    fetch_req(32'h10C0, lat_a);
`endif

    repeat (4) @(posedge clk);
    check("q_if_drained", q_if.size(), 0);
    check("q_d_drained", q_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
